// File: rtl/regbank_dump_ctrl.sv
// Debug-side register bank dumper: walks every register through read port 1 and
// streams it out little-endian, one byte per valid/ready transfer.
module regbank_dump_ctrl #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_REG  = 5,
    parameter int unsigned NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_REG-1:0]  i_pipe_read_reg1,
    output logic [NB_REG-1:0]  o_read_reg1,
    input  logic [NB_DATA-1:0] i_register1,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam int unsigned NbBytes = NB_DATA / NB_BYTE;
    localparam int unsigned ByteW   = (NbBytes > 1) ? $clog2(NbBytes) : 1;
    localparam logic [ByteW-1:0]  LastByte = ByteW'(NbBytes - 1);
    localparam logic [NB_REG-1:0] LastReg  = '1;

    typedef enum logic [2:0] {StIdle, StAddr, StLatch, StSend, StNext} state_e;

    state_e               state_q, state_d;
    logic [NB_REG-1:0]    reg_idx_q, reg_idx_d;
    logic [ByteW-1:0]     byte_idx_q, byte_idx_d;
    logic [NB_DATA-1:0]   word_q, word_d;
    logic                 done_q, done_d;
    logic                 tx_fire;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            reg_idx_q  <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            reg_idx_q  <= reg_idx_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            done_q     <= done_d;
        end
    end

    assign tx_fire = (state_q == StSend) && i_tx_ready;

    always_comb begin
        state_d    = state_q;
        reg_idx_d  = reg_idx_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    reg_idx_d = '0;
                    state_d   = StAddr;
                end
            end
            // One idle address cycle lets a registered bank read settle before LATCH.
            StAddr: state_d = StLatch;
            StLatch: begin
                word_d     = i_register1;
                byte_idx_d = '0;
                state_d    = StSend;
            end
            StSend: begin
                if (tx_fire) begin
                    if (byte_idx_q == LastByte) begin
                        state_d = StNext;
                    end else begin
                        byte_idx_d = byte_idx_q + ByteW'(1);
                    end
                end
            end
            StNext: begin
                if (reg_idx_q == LastReg) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    reg_idx_d = reg_idx_q + NB_REG'(1);
                    state_d   = StAddr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_busy      = (state_q != StIdle);
        o_tx_valid  = (state_q == StSend);
        o_tx_data   = o_tx_valid ? word_q[byte_idx_q*NB_BYTE +: NB_BYTE] : '0;
        o_read_reg1 = o_busy ? reg_idx_q : i_pipe_read_reg1;
        o_done      = done_q;
    end

endmodule

// File: doc/regbank_dump_ctrl.md
# regbank_dump_ctrl

Debug-side controller for the register bank of the pipelined MIPS core. On a start request, issued while the pipeline is halted, it takes over read port 1 of the register bank. It walks all 2**NB_REG registers in ascending order and streams each register out as NB_DATA/8 bytes over a valid/ready byte interface toward the debug UART transmitter. When idle, it passes the pipeline's read-port-1 address straight through to the bank.

## Interface
- NB_DATA, 32, register width in bits; must be a multiple of 8.
- NB_REG, 5, register address width; the bank holds 2**NB_REG registers.
- NB_BYTE, 8, output byte width.

- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  dump request; sampled only in IDLE.
- i_pipe_read_reg1  in  NB_REG  pipeline's read-port-1 address.
- o_read_reg1  out  NB_REG  address driven to register_bank i_read_reg1.
- i_register1  in  NB_DATA  register_bank o_register1.
- o_tx_data  out  NB_BYTE  byte to transmitter.
- o_tx_valid  out  1  o_tx_data valid.
- i_tx_ready  in  1  transmitter accepts the byte this cycle.
- o_busy  out  1  dump in progress; the pipeline must stay halted.
- o_done  out  1  one-cycle pulse when the dump completes.

## Operation
- Registered state: FSM state, reg_idx (NB_REG bits), byte_idx (clog2(NB_DATA/8) bits), shift word (NB_DATA bits), done flag.
- IDLE:
  - o_read_reg1 = i_pipe_read_reg1 (combinational pass-through); o_busy = 0; o_tx_valid = 0.
  - On i_start: reg_idx <= 0, go to ADDR.
- ADDR:
  - o_read_reg1 = reg_idx. Hold for one cycle, then go to LATCH.
  - This tolerates a bank read latency of 0 or 1 cycle.
- LATCH:
  - o_read_reg1 = reg_idx; word <= i_register1; byte_idx <= 0; go to SEND.
- SEND:
  - o_tx_valid = 1; o_tx_data = word[byte_idx*8 +: 8]. Bytes go out little-endian, so byte 0 is bits 7:0.
  - On o_tx_valid && i_tx_ready: if byte_idx == NB_DATA/8-1, go to NEXT; otherwise byte_idx++.
- NEXT:
  - If reg_idx == 2**NB_REG-1: go to IDLE and set done for the next cycle.
  - Otherwise: reg_idx++ and go to ADDR.
- o_busy = 1 in every state except IDLE. o_read_reg1 = reg_idx whenever o_busy = 1.
- o_done is registered and high only in the first IDLE cycle after a completed dump.
- i_start while busy is ignored; it is neither queued nor restarts the dump.
- The block never writes the bank. Write-port arbitration is outside this block.

## Timing
- Reset values: state IDLE, reg_idx 0, byte_idx 0, word 0; o_tx_valid 0, o_busy 0, o_done 0, o_tx_data 0x00.
  - o_read_reg1 = i_pipe_read_reg1 during reset.
- i_start sampled high at edge E0 → o_busy = 1 from the cycle after E0 (ADDR).
- Per register with i_tx_ready held at 1: ADDR 1 + LATCH 1 + SEND 4 + NEXT 1 = 7 cycles.
  - Full dump: 224 busy cycles, with o_done high in cycle 225 after E0.
- Handshake rules:
  - Once o_tx_valid rises, it stays high and o_tx_data stays stable until accepted.
  - A transfer occurs only on an edge where valid && ready are both high.
  - Each byte transfers exactly once.
  - i_tx_ready is allowed high while valid is low; no transfer occurs.
- Wrap-around: reg_idx never wraps. The NEXT state at index 2**NB_REG-1 terminates the dump.
- Reset mid-operation: reset high at any edge returns the block to IDLE at that edge.
  - o_tx_valid and o_busy go low the next cycle; no o_done pulse is generated.
  - A partially sent word is discarded.
- Reset and i_start at the same edge: reset wins and the block stays IDLE.
- i_start in the o_done cycle is accepted, because the state is IDLE.

## Test plan
- Reset, then pulse i_start with ready=1 on a freshly reset bank → 128 bytes, all 0x00.
  - o_busy is high for exactly 224 cycles, o_done pulses once in cycle 225, and o_busy is low in the o_done cycle.
- Write reg5=0xDEADBEEF and reg31=0x12345678 through the bank, then dump.
  - Byte stream positions 20..23 = EF BE AD DE and 124..127 = 78 56 34 12.
  - All other bytes are 0x00.
- Backpressure: drop i_tx_ready for 3 cycles at byte 2 of reg 3, and toggle ready every cycle during reg 4.
  - o_tx_valid and o_tx_data hold steady while stalled.
  - The received stream is identical to the ready=1 run, with no loss or duplication.
- Pass-through: in IDLE, drive i_pipe_read_reg1=7 → o_read_reg1=7 in the same cycle.
  - During the dump, change i_pipe_read_reg1 → o_read_reg1 follows only reg_idx.
- Pulse i_start during reg 10 → no effect, and the dump still ends at cycle 225.
- Reset during reg 10 SEND → next cycle o_tx_valid=0 and o_busy=0, with no o_done.
  - A new i_start restarts the dump from reg0, byte 0.
